// File: rtl/ysyx_23060061_lsu_axi.sv
// ysyx_23060061_lsu_axi
// ---------------------------------------------------------------------------
// Load/store unit behind the ID/EX stage. It takes one memory request per EXU
// handshake and runs it as a single-beat AXI4-Lite read or write. It then
// returns aligned, extended load data to the WBU through a valid/ready
// handshake. Only one request is outstanding at a time.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   exu_valid / lsu_ready    request handshake (lsu_ready only while idle)
//   MemRW                    01 load, 10 store, 00/11 no memory access
//   memExt                   000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (others = lw)
//   memAddr                  byte address
//   memDataW, wmask          LSB-justified store data and byte mask
//   lsu_valid / wbu_ready    result handshake towards the WBU
//   memDataR                 extended load data, 0 for stores / no-access
//   ar*, r*                  AXI4-Lite read address / read data channels
//   aw*, w*, b*              AXI4-Lite write address / data / response channels
// ---------------------------------------------------------------------------
module ysyx_23060061_lsu_axi #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // EXU side
    input  logic              exu_valid,
    output logic              lsu_ready,
    input  logic [1:0]        MemRW,
    input  logic [2:0]        memExt,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [31:0]       memDataW,
    input  logic [3:0]        wmask,
    // WBU side
    output logic              lsu_valid,
    input  logic              wbu_ready,
    output logic [31:0]       memDataR,
    // AXI4-Lite read
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    // AXI4-Lite write
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4,
        DONE = 3'd5
    } lsuState_t;

    lsuState_t state;

    // Latched request. The access kind (MemRW) is carried by the state
    // itself, so it is not kept as a separate register.
    logic [2:0]        reqMemExt;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqDataW;
    logic [3:0]        reqWmask;

    logic [1:0]  byteOff;
    logic [31:0] loadShifted;
    logic [31:0] loadExt;
    logic        awDone;
    logic        wDone;

    assign byteOff   = reqAddr[1:0];
    assign lsu_ready = (state == IDLE);

    // Address, data and strobe are derived from the latched request. They
    // therefore stay stable for the whole time the matching valid is high.
    assign araddr = {reqAddr[ADDR_W-1:2], 2'b00};
    assign awaddr = {reqAddr[ADDR_W-1:2], 2'b00};
    assign wdata  = reqDataW << {byteOff, 3'b000};
    // Strobe bits shifted past lane 3 fall off the 4-bit result.
    assign wstrb  = reqWmask << byteOff;

    // Move the addressed byte lane down to bit 0, then extend it.
    assign loadShifted = rdata >> {byteOff, 3'b000};

    always_comb begin
        loadExt = loadShifted;
        case (reqMemExt)
            3'b000:  loadExt = {{24{loadShifted[7]}},  loadShifted[7:0]};
            3'b001:  loadExt = {{16{loadShifted[15]}}, loadShifted[15:0]};
            3'b100:  loadExt = {24'd0, loadShifted[7:0]};
            3'b101:  loadExt = {16'd0, loadShifted[15:0]};
            default: loadExt = loadShifted;
        endcase
    end

    // A write channel counts as finished once its valid has dropped, or
    // when it completes its handshake in this cycle. This covers AW and W
    // completing in the same cycle as well as in either order.
    assign awDone = !awvalid || awready;
    assign wDone  = !wvalid  || wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            reqMemExt <= '0;
            reqAddr   <= '0;
            reqDataW  <= '0;
            reqWmask  <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            lsu_valid <= 1'b0;
            memDataR  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exu_valid) begin
                        reqMemExt <= memExt;
                        reqAddr   <= memAddr;
                        reqDataW  <= memDataW;
                        reqWmask  <= wmask;
                        memDataR  <= '0;
                        case (MemRW)
                            2'b01: begin
                                arvalid <= 1'b1;
                                state   <= AR;
                            end
                            2'b10: begin
                                awvalid <= 1'b1;
                                wvalid  <= 1'b1;
                                state   <= AW_W;
                            end
                            default: begin
                                lsu_valid <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        memDataR  <= loadExt;
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                AW_W: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    if (awDone && wDone) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        memDataR  <= '0;
                        lsu_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (wbu_ready) begin
                        lsu_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_lsu_axi.sv
module tb_ysyx_23060061_lsu_axi;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        lsu_ready;
    logic [1:0]  MemRW;
    logic [2:0]  memExt;
    logic [31:0] memAddr;
    logic [31:0] memDataW;
    logic [3:0]  wmask;
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] memDataR;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int nChecks = 0;
    int nFail   = 0;
    int txnNum  = 0;

    ysyx_23060061_lsu_axi #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .MemRW(MemRW), .memExt(memExt), .memAddr(memAddr),
        .memDataW(memDataW), .wmask(wmask),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .memDataR(memDataR),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: request fields, slave stall counts (handshake cycles
    // withheld per channel), WBU stall count and the expected results.
    typedef struct {
        logic [1:0]  memRW;
        logic [2:0]  ext;
        logic [31:0] addr;
        logic [31:0] dataW;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          arStall, rStall, awStall, wStall, bStall, wbuStall;
        logic [31:0] expData;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [3:0]  expStrb;
        int          expLat;
    } txn_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h (txn %0d, t=%0t)", name, act, exp, txnNum, $time);
        end
    endtask

    function automatic txn_t mk(input logic [1:0] rw, input logic [2:0] ext,
                                input logic [31:0] addr, input logic [31:0] dataW,
                                input logic [3:0] wm, input logic [31:0] rd,
                                input int arS, input int rS, input int awS,
                                input int wS, input int bS, input int wbuS,
                                input logic [31:0] eData, input logic [31:0] eAddr,
                                input logic [31:0] eWdata, input logic [3:0] eStrb,
                                input int eLat);
        txn_t t;
        t.memRW = rw; t.ext = ext; t.addr = addr; t.dataW = dataW; t.wmask = wm;
        t.rdata = rd; t.arStall = arS; t.rStall = rS; t.awStall = awS;
        t.wStall = wS; t.bStall = bS; t.wbuStall = wbuS;
        t.expData = eData; t.expAddr = eAddr; t.expWdata = eWdata;
        t.expStrb = eStrb; t.expLat = eLat;
        return t;
    endfunction

    // Reference model: byte-lane arithmetic on plain integers.
    function automatic txn_t model(input txn_t t);
        txn_t        r;
        int          off;
        logic [31:0] sh;
        logic [31:0] v;
        logic [63:0] wide;
        r    = t;
        off  = int'(t.addr % 4);
        r.expAddr = t.addr - 32'(off);
        sh   = t.rdata / (32'd1 << (8 * off));
        case (t.ext)
            3'b000: begin v = sh % 256;   r.expData = (v >= 128)   ? v - 32'd256   : v; end
            3'b001: begin v = sh % 65536; r.expData = (v >= 32768) ? v - 32'd65536 : v; end
            3'b100: r.expData = sh % 256;
            3'b101: r.expData = sh % 65536;
            default: r.expData = sh;
        endcase
        r.expStrb  = 4'((32'(t.wmask) * 32'(2 ** off)) % 16);
        wide       = 64'(t.dataW) * 64'(2 ** (8 * off));
        r.expWdata = wide[31:0];
        if (t.memRW == 2'b01) begin
            r.expLat = 3 + t.arStall + t.rStall;
        end else if (t.memRW == 2'b10) begin
            r.expData = 32'd0;
            r.expLat  = 3 + ((t.awStall > t.wStall) ? t.awStall : t.wStall) + t.bStall;
        end else begin
            r.expData = 32'd0;
            r.expLat  = 1;
        end
        return r;
    endfunction

    task automatic idleSlave();
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        rdata = 32'd0; wbu_ready = 0;
    endtask

    // Drives a request and plays slave/WBU; inputs change and outputs are
    // observed on the falling edge.
    task automatic run_txn(input txn_t t);
        int c, arN, rN, awN, wN, bN, dN, firstDone;
        bit fin;
        logic [31:0] held;
        bit isLoad, isStore;
        isLoad  = (t.memRW == 2'b01);
        isStore = (t.memRW == 2'b10);
        @(negedge clk);
        chk("ready_before_req", 32'(lsu_ready), 32'd1);
        idleSlave();
        exu_valid = 1; MemRW = t.memRW; memExt = t.ext; memAddr = t.addr;
        memDataW = t.dataW; wmask = t.wmask;
        c = 0; arN = 0; rN = 0; awN = 0; wN = 0; bN = 0; dN = 0;
        firstDone = -1; fin = 0; held = '0;
        while (!fin) begin
            @(negedge clk);
            c++;
            if (c > 200) begin
                chk("txn_timeout", 32'(c), 32'd200);
                break;
            end
            // Junk on the request port must be ignored while busy.
            exu_valid = 1'($urandom); MemRW = 2'($urandom); memExt = 3'($urandom);
            memAddr = $urandom; memDataW = $urandom; wmask = 4'($urandom);
            arready = 0; awready = 0; wready = 0; wbu_ready = 0;
            rvalid = 1'($urandom); bvalid = 1'($urandom); rdata = $urandom;
            chk("busy_not_ready", 32'(lsu_ready), 32'd0);
            if (!isLoad) begin
                chk("no_arvalid", 32'(arvalid), 32'd0);
                chk("no_rready", 32'(rready), 32'd0);
            end
            if (!isStore) begin
                chk("no_awvalid", 32'(awvalid), 32'd0);
                chk("no_wvalid", 32'(wvalid), 32'd0);
                chk("no_bready", 32'(bready), 32'd0);
            end
            if (arvalid) begin
                chk("araddr", araddr, t.expAddr);
                arready = (arN == t.arStall);
                arN++;
            end
            if (rready) begin
                rvalid = (rN == t.rStall);
                if (rvalid) rdata = t.rdata;
                rN++;
            end
            if (awvalid) begin
                chk("awaddr", awaddr, t.expAddr);
                awready = (awN == t.awStall);
                awN++;
            end
            if (wvalid) begin
                chk("wdata", wdata, t.expWdata);
                chk("wstrb", 32'(wstrb), 32'(t.expStrb));
                wready = (wN == t.wStall);
                wN++;
            end
            if (bready) begin
                bvalid = (bN == t.bStall);
                bN++;
            end
            if (lsu_valid) begin
                if (firstDone < 0) begin
                    firstDone = c;
                    chk("latency", 32'(c), 32'(t.expLat));
                    chk("memDataR", memDataR, t.expData);
                    held = memDataR;
                end else begin
                    chk("memDataR_held", memDataR, held);
                end
                wbu_ready = (dN == t.wbuStall);
                fin = wbu_ready;
                dN++;
            end else begin
                wbu_ready = 1'($urandom);
            end
        end
        @(negedge clk);
        exu_valid = 0;
        idleSlave();
        chk("ready_after", 32'(lsu_ready), 32'd1);
        chk("valid_cleared", 32'(lsu_valid), 32'd0);
        chk("ar_beats", 32'(arN), isLoad  ? 32'(t.arStall + 1) : 32'd0);
        chk("r_beats",  32'(rN),  isLoad  ? 32'(t.rStall + 1)  : 32'd0);
        chk("aw_beats", 32'(awN), isStore ? 32'(t.awStall + 1) : 32'd0);
        chk("w_beats",  32'(wN),  isStore ? 32'(t.wStall + 1)  : 32'd0);
        chk("b_beats",  32'(bN),  isStore ? 32'(t.bStall + 1)  : 32'd0);
        $display("txn %0d rw=%b ext=%b addr=%h lat=%0d data=%h exp=%h",
                 txnNum, t.memRW, t.ext, t.addr, firstDone, held, t.expData);
        txnNum++;
    endtask

    txn_t tbl[$];
    txn_t rt;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 0; exu_valid = 0; MemRW = 0; memExt = 0; memAddr = 0;
        memDataW = 0; wmask = 0;
        idleSlave();

        //        rw     ext     addr          dataW         wm     rdata        ar r aw w b wbu expData       expAddr       expWdata      strb    lat
        tbl.push_back(mk(2'b01, 3'b100, 32'h8000_0003, 32'h0,        4'h0, 32'h80AB_CDEF, 0,0,0,0,0,0, 32'h0000_0080, 32'h8000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b01, 3'b001, 32'h8000_0002, 32'h0,        4'h0, 32'h8001_1234, 0,0,0,0,0,0, 32'hFFFF_8001, 32'h8000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b01, 3'b101, 32'h8000_0002, 32'h0,        4'h0, 32'h8001_1234, 0,0,0,0,0,0, 32'h0000_8001, 32'h8000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b10, 3'b000, 32'h8000_0001, 32'h0000_00A5, 4'h1, 32'h0,        0,0,3,0,0,0, 32'h0,         32'h8000_0000, 32'h0000_A500, 4'b0010, 6));
        tbl.push_back(mk(2'b00, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF, 4'hF, 32'h0,        0,0,0,0,0,4, 32'h0,         32'h0,         32'h0,        4'b0000, 1));
        tbl.push_back(mk(2'b11, 3'b010, 32'h0000_0004, 32'h0,        4'h0, 32'h0,        0,0,0,0,0,0, 32'h0,         32'h0,         32'h0,        4'b0000, 1));
        tbl.push_back(mk(2'b01, 3'b010, 32'h0000_0010, 32'h0,        4'h0, 32'h1234_5678, 2,1,0,0,0,0, 32'h1234_5678, 32'h0000_0010, 32'h0,        4'b0000, 6));
        tbl.push_back(mk(2'b01, 3'b000, 32'h0000_0101, 32'h0,        4'h0, 32'h0000_FF00, 0,0,0,0,0,0, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b10, 3'b000, 32'h0000_0102, 32'h0000_BEEF, 4'h3, 32'h0,        0,0,0,2,1,0, 32'h0,         32'h0000_0100, 32'hBEEF_0000, 4'b1100, 6));
        tbl.push_back(mk(2'b10, 3'b010, 32'h0000_0203, 32'h1122_3344, 4'hF, 32'h0,        0,0,0,0,0,0, 32'h0,         32'h0000_0200, 32'h4400_0000, 4'b1000, 3));
        tbl.push_back(mk(2'b01, 3'b011, 32'h0000_0000, 32'h0,        4'h0, 32'hCAFE_F00D, 0,0,0,0,0,0, 32'hCAFE_F00D, 32'h0000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b01, 3'b001, 32'h0000_0003, 32'h0,        4'h0, 32'hF012_3456, 0,0,0,0,0,0, 32'h0000_00F0, 32'h0000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b01, 3'b010, 32'h0000_0002, 32'h0,        4'h0, 32'hAABB_CCDD, 0,0,0,0,0,0, 32'h0000_AABB, 32'h0000_0000, 32'h0,        4'b0000, 3));
        tbl.push_back(mk(2'b01, 3'b000, 32'h8000_0003, 32'h0,        4'h0, 32'h80AB_CDEF, 0,0,0,0,0,0, 32'hFFFF_FF80, 32'h8000_0000, 32'h0,        4'b0000, 3));

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_lsu_valid", 32'(lsu_valid), 32'd0);
        chk("rst_memDataR", memDataR, 32'd0);
        chk("rst_axi_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        rst = 1;

        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset in the middle of a stalled read.
        @(negedge clk);
        exu_valid = 1; MemRW = 2'b01; memExt = 3'b010; memAddr = 32'h8000_0044;
        idleSlave();
        @(negedge clk);
        exu_valid = 0;
        chk("midrst_arvalid_c1", 32'(arvalid), 32'd1);
        @(negedge clk);
        chk("midrst_arvalid_c2", 32'(arvalid), 32'd1);
        @(negedge clk);
        rst = 0;
        #1;
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_ready", 32'(lsu_ready), 32'd1);
        chk("midrst_lsu_valid", 32'(lsu_valid), 32'd0);
        chk("midrst_araddr", araddr, 32'd0);
        $display("txn %0d reset pulsed during AR stall", txnNum);
        txnNum++;
        @(negedge clk);
        rst = 1;
        run_txn(tbl[0]);

        // Randomized transactions against the reference model.
        for (int k = 0; k < 40; k++) begin
            rt.memRW    = 2'($urandom);
            rt.ext      = 3'($urandom);
            rt.addr     = $urandom;
            rt.dataW    = $urandom;
            case ($urandom_range(0, 2))
                0:       rt.wmask = 4'b0001;
                1:       rt.wmask = 4'b0011;
                default: rt.wmask = 4'b1111;
            endcase
            rt.rdata    = $urandom;
            rt.arStall  = $urandom_range(0, 3);
            rt.rStall   = $urandom_range(0, 3);
            rt.awStall  = $urandom_range(0, 3);
            rt.wStall   = $urandom_range(0, 3);
            rt.bStall   = $urandom_range(0, 3);
            rt.wbuStall = $urandom_range(0, 2);
            run_txn(model(rt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
